// File: rtl/div32_seq.sv
// div32_seq -- multi-cycle restoring divider for the execute stage (DIV/DIVU).
//
// One quotient bit is produced per clock. The quotient goes to LO and the
// remainder to HI. The pipeline controller stalls the stage while busy is high.
//
// Optional build macro: DIV_ZERO_FAST_EN
//   When it is defined, a zero divisor skips the shift-subtract loop. The block
//   then returns quotient=all-ones and remainder=dividend (raw, with no sign
//   fixup), and pulses div_zero together with done.
//   When it is undefined, a zero divisor runs the full loop and div_zero is
//   tied low.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset; aborts any operation in flight
//   start      request, sampled only while idle
//   is_signed  1 = two's-complement divide, 0 = unsigned (sampled with start)
//   dividend   numerator (sampled with start)
//   divisor    denominator (sampled with start)
//   busy       high while an operation is in flight
//   done       one-cycle pulse; quotient/remainder are valid from this cycle
//   quotient   result to LO, held until the next done
//   remainder  result to HI, held until the next done
//   div_zero   pulses with done when the divisor was zero (fast build only)
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, mag_d;
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] mag_dividend, mag_divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial_lo;
    logic             borrow;
`ifdef DIV_ZERO_FAST_EN
    logic             zero_op;
`endif

    // Magnitudes are taken only for signed operations.
    assign mag_dividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_divisor  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The next dividend bit enters the partial remainder from the top of
    // quo_r. quo_r starts out holding |dividend|, and quotient bits fill it
    // from the bottom as the dividend bits shift out of the top.
    assign shifted  = {rem_r, quo_r[WIDTH-1]};
    assign borrow   = shifted < {1'b0, mag_d};
    // Without a borrow the difference is below mag_d, so the low WIDTH bits
    // of a modular subtract already hold the exact value.
    assign trial_lo = shifted[WIDTH-1:0] - mag_d;

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
`ifdef DIV_ZERO_FAST_EN
                state_nxt = (divisor == '0) ? FIX : CALC;
`else
                state_nxt = CALC;
`endif
            end
            CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            mag_d     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
            zero_op   <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            div_zero <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    rem_r  <= '0;
                    quo_r  <= mag_dividend;
                    mag_d  <= mag_divisor;
                    sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    sign_r <= is_signed & dividend[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
                    zero_op <= (divisor == '0);
                    // Preload the raw result so FIX passes it through unchanged.
                    if (divisor == '0) begin
                        quo_r  <= '1;
                        rem_r  <= dividend;
                        sign_q <= 1'b0;
                        sign_r <= 1'b0;
                    end
`endif
                end
                CALC: begin
                    cnt   <= cnt + 1'b1;
                    quo_r <= {quo_r[WIDTH-2:0], ~borrow};
                    if (!borrow) rem_r <= trial_lo;
                    else         rem_r <= shifted[WIDTH-1:0];
                end
                FIX: begin
                    quotient  <= sign_q ? -quo_r : quo_r;
                    remainder <= sign_r ? -rem_r : rem_r;
                    done      <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    div_zero  <= zero_op;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef DIV_ZERO_FAST_EN
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq -- randomized and directed scoreboard bench for div32_seq.
// The driver pushes the expected result and completion cycle of each accepted
// start. The monitor checks busy, done, the held results and div_zero on
// every falling edge.
module tb_div32_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_zero;
    logic [31:0] quotient, remainder;

    div32_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          busy_lo = 1, busy_hi = 0;
    int          held_clr = -1;
    logic [31:0] hq = '0, hr = '0;
    int          n_chk = 0, n_pass = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    endtask

    // Reference model taken straight from the arithmetic definition.
    function automatic exp_t model(input logic sg, input logic [31:0] a,
                                   input logic [31:0] b, input int c0);
        exp_t   e;
        longint x, y;
        e.dz  = 1'b0;
        e.cyc = c0 + 34;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            e.q = 32'hFFFFFFFF; e.r = a; e.dz = 1'b1; e.cyc = c0 + 2;
`else
            e.q = (sg && a[31]) ? 32'd1 : 32'hFFFFFFFF; e.r = a;
`endif
        end else if (sg) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            e.q = 32'(x / y);
            e.r = 32'(x % y);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drive one cycle of inputs and advance to just after the next rising edge.
    task automatic drive(input logic st, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic rs);
        exp_t e;
        reset = rs; start = st; is_signed = sg; dividend = a; divisor = b;
        if (rs) begin
            sb.delete();
            busy_lo = 1; busy_hi = 0;
            held_clr = cyc + 1;
        end else if (st && !(cyc >= busy_lo && cyc <= busy_hi)) begin
            e = model(sg, a, b, cyc);
            sb.push_back(e);
            busy_lo = cyc + 1;
            busy_hi = e.cyc - 1;
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() > 0 && k < 200) begin
            idle(1);
            k++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        idle(1);
    endtask

    task automatic op(input logic sg, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, sg, a, b, 1'b0);
        wait_drain();
    endtask

    // Monitor: compare everything the DUT shows against the scoreboard.
    logic exp_done, exp_busy, dz_exp;
    exp_t m;
    always @(negedge clock) begin
        if (!reset) begin
            if (cyc == held_clr) begin hq = '0; hr = '0; end
            exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            dz_exp   = 1'b0;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                m = sb.pop_front();
                hq = m.q; hr = m.r; dz_exp = m.dz;
            end
            chk("quotient", quotient, hq);
            chk("remainder", remainder, hr);
            chk("div_zero", 32'(div_zero), 32'(dz_exp));
            if (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
        end
    end

    initial begin
        logic [31:0] a, b;
        logic        sg;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(2);

        // Directed values and extremes.
        op(1'b0, 32'd100, 32'd7);
        op(1'b1, 32'hFFFFFF9C, 32'd7);
        op(1'b1, 32'd100, 32'hFFFFFFF9);
        op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        op(1'b0, 32'hFFFFFFFF, 32'd1);
        op(1'b0, 32'd5, 32'd9);
        op(1'b0, 32'h12345678, 32'd0);
        op(1'b1, 32'h12345678, 32'd0);
        op(1'b1, 32'hEDCBA988, 32'd0);
        op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFF9);

        // A start pulse while busy must be ignored.
        drive(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
        idle(5);
        drive(1'b1, 1'b0, 32'd77, 32'd5, 1'b0);
        wait_drain();

        // Start held high: operations run back to back with changing operands.
        for (int i = 0; i < 150; i++)
            drive(1'b1, 1'($urandom), $urandom, $urandom_range(1, 1000), 1'b0);
        wait_drain();

        // Reset in cycle 10 of an operation, then a fresh operation.
        drive(1'b1, 1'b0, 32'd500, 32'd9, 1'b0);
        idle(9);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(3);
        op(1'b0, 32'd500, 32'd9);

        // Random traffic; starts that land while busy exercise the ignore path.
        for (int i = 0; i < 1500; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2, 3, 4: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            drive(($urandom_range(0, 7) == 0), sg, a, b, 1'b0);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
